// File: rtl/extbus_responder.sv
// rtl/extbus_responder.sv - asynchronous host bus to clk25 register-port bridge
//
// Purpose: samples an asynchronous 8-bit host bus (chip select, read/write
// strobes, 5-bit address, data) into the clk25 domain and turns every
// completed access into a single one-cycle strobe toward the register core.
//
// Ports:
//   clk25, rst          sole clock, synchronous active-high reset
//   extbus_cs_n/rd_n/wr_n, extbus_a, extbus_d_in
//                       asynchronous host bus inputs
//   extbus_d_out/d_oe   read data and output enable back to the host
//   reg_addr, reg_wrdata, reg_write
//                       register address, write data and write strobe
//   reg_rddata          combinational core read data for reg_addr
//   reg_read_done       one-cycle strobe after a read access ends
//   bus_err             sticky flag for illegal strobe combinations
module extbus_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ACTIVE  = 1
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       extbus_cs_n,
  input  logic       extbus_rd_n,
  input  logic       extbus_wr_n,
  input  logic [4:0] extbus_a,
  input  logic [7:0] extbus_d_in,
  output logic [7:0] extbus_d_out,
  output logic       extbus_d_oe,
  output logic [4:0] reg_addr,
  output logic [7:0] reg_wrdata,
  output logic       reg_write,
  input  logic [7:0] reg_rddata,
  output logic       reg_read_done,
  output logic       bus_err
);

  localparam int CW = (MIN_ACTIVE < 1) ? 1 : $clog2(MIN_ACTIVE + 1);
  localparam logic [CW-1:0] MIN_CNT    = CW'(MIN_ACTIVE);
  localparam logic [1:0]    FLUSH_DONE = 2'(SYNC_STAGES);

  typedef enum logic [1:0] {IDLE, WR_ACTIVE, RD_ACTIVE, ERR} state_e;

  // Pin synchronizers: all bus pins share the same chain depth so the last
  // stage is a coherent snapshot of one sampling instant.
  logic [SYNC_STAGES-1:0] cs_sync_q, rd_sync_q, wr_sync_q;
  logic [4:0]             a_sync_q [SYNC_STAGES];
  logic [7:0]             d_sync_q [SYNC_STAGES];

  always_ff @(posedge clk25) begin
    if (rst) begin
      cs_sync_q <= '1;
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        a_sync_q[i] <= '0;
        d_sync_q[i] <= '0;
      end
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], extbus_cs_n};
      rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], extbus_rd_n};
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], extbus_wr_n};
      a_sync_q[0] <= extbus_a;
      d_sync_q[0] <= extbus_d_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        a_sync_q[i] <= a_sync_q[i-1];
        d_sync_q[i] <= d_sync_q[i-1];
      end
    end
  end

  logic       cs_s, rd_s, wr_s;
  logic [4:0] a_s;
  logic [7:0] d_s;
  logic       wr_act, rd_act;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign rd_s   = rd_sync_q[SYNC_STAGES-1];
  assign wr_s   = wr_sync_q[SYNC_STAGES-1];
  assign a_s    = a_sync_q[SYNC_STAGES-1];
  assign d_s    = d_sync_q[SYNC_STAGES-1];
  // A deselected chip ends any access even if a strobe is still low.
  assign wr_act = !cs_s && !wr_s;
  assign rd_act = !cs_s && !rd_s;

  // Output enable is taken straight from the pins so the host sees data
  // without synchronizer latency.
  assign extbus_d_oe = !extbus_cs_n && !extbus_rd_n && !rst;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]    addr_hold_q, addr_hold_d;
  logic [7:0]    data_hold_q, data_hold_d;
  logic [4:0]    reg_addr_q, reg_addr_d;
  logic [7:0]    reg_wrdata_q, reg_wrdata_d;
  logic          reg_write_q, reg_write_d;
  logic          read_done_q, read_done_d;
  logic          bus_err_q, bus_err_d;
  logic [7:0]    d_out_q, d_out_d;
  logic          rd_first_q, rd_first_d;
  // After reset the chains first have to refill with real pin samples
  // (flush_q), and then both strobes must be seen inactive (armed_q) before
  // an access may start; a strobe held low across reset is thereby ignored.
  logic [1:0]    flush_q, flush_d;
  logic          armed_q, armed_d;

  assign cnt_inc = (cnt_q >= MIN_CNT) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_hold_q  <= '0;
      data_hold_q  <= '0;
      reg_addr_q   <= '0;
      reg_wrdata_q <= '0;
      reg_write_q  <= 1'b0;
      read_done_q  <= 1'b0;
      bus_err_q    <= 1'b0;
      d_out_q      <= '0;
      rd_first_q   <= 1'b0;
      flush_q      <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_hold_q  <= addr_hold_d;
      data_hold_q  <= data_hold_d;
      reg_addr_q   <= reg_addr_d;
      reg_wrdata_q <= reg_wrdata_d;
      reg_write_q  <= reg_write_d;
      read_done_q  <= read_done_d;
      bus_err_q    <= bus_err_d;
      d_out_q      <= d_out_d;
      rd_first_q   <= rd_first_d;
      flush_q      <= flush_d;
      armed_q      <= armed_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_hold_d  = addr_hold_q;
    data_hold_d  = data_hold_q;
    reg_addr_d   = reg_addr_q;
    reg_wrdata_d = reg_wrdata_q;
    reg_write_d  = 1'b0;
    read_done_d  = 1'b0;
    bus_err_d    = bus_err_q;
    d_out_d      = d_out_q;
    rd_first_d   = 1'b0;
    flush_d      = (flush_q == FLUSH_DONE) ? flush_q : flush_q + 2'd1;
    armed_d      = armed_q;

    if (flush_q == FLUSH_DONE && !wr_act && !rd_act) begin
      armed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        reg_addr_d = a_s;
        d_out_d    = reg_rddata;
        cnt_d      = '0;
        if (armed_q) begin
          if (wr_act && rd_act) begin
            state_d   = ERR;
            bus_err_d = 1'b1;
          end else if (wr_act) begin
            state_d     = WR_ACTIVE;
            addr_hold_d = a_s;
            data_hold_d = d_s;
            cnt_d       = cnt_inc;
          end else if (rd_act) begin
            state_d    = RD_ACTIVE;
            cnt_d      = cnt_inc;
            rd_first_d = 1'b1;
          end
        end
      end
      WR_ACTIVE: begin
        if (rd_act) begin
          state_d   = ERR;
          bus_err_d = 1'b1;
          cnt_d     = '0;
        end else if (wr_act) begin
          addr_hold_d = a_s;
          data_hold_d = d_s;
          cnt_d       = cnt_inc;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          if (cnt_q >= MIN_CNT) begin
            reg_write_d  = 1'b1;
            reg_addr_d   = addr_hold_q;
            reg_wrdata_d = data_hold_q;
          end
        end
      end
      RD_ACTIVE: begin
        // reg_addr loads the read address on the entry edge, so the core's
        // data for it is only valid one cycle later: capture once more here.
        if (rd_first_q) begin
          d_out_d = reg_rddata;
        end
        if (wr_act) begin
          state_d   = ERR;
          bus_err_d = 1'b1;
          cnt_d     = '0;
        end else if (rd_act) begin
          cnt_d = cnt_inc;
        end else begin
          state_d     = IDLE;
          cnt_d       = '0;
          read_done_d = (cnt_q >= MIN_CNT);
        end
      end
      ERR: begin
        bus_err_d = 1'b1;
        cnt_d     = '0;
        if (!wr_act && !rd_act) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign reg_addr      = reg_addr_q;
  assign reg_wrdata    = reg_wrdata_q;
  assign reg_write     = reg_write_q;
  assign reg_read_done = read_done_q;
  assign bus_err       = bus_err_q;
  assign extbus_d_out  = d_out_q;

endmodule
